ddr_port_arbiter: RTL and testbench

Arbitrates the single memory-controller port between the instruction-fetch channel (512-bit burst line reads) and the load/store channel (64-bit masked reads and writes). It sits between the core's fetch and LSU request logic and the DDR model. It issues exactly one DDR operation at a time: a one-cycle chip-enable pulse, then command fields held stable until `ddr_operation_done`. It also returns each response to the requester that issued it.

---
 rtl/ddr_pkg.sv | 30 +++
 rtl/ddr_port_arbiter_rr_arb2.sv | 36 +++
 rtl/ddr_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and widths for the DDR port arbiter: bus widths, FSM state
// encoding, request owner and the latched DDR command.
package ddr_pkg;

    localparam int IDX_W  = 19;
    localparam int LS_W   = 64;
    localparam int LINE_W = 512;
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        PC = 1'b0,
        LS = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             we;
        logic             burst;
        logic [LS_W-1:0]  mask;
        logic [LS_W-1:0]  data;
    } ddr_cmd_t;

endpackage

// File: rtl/ddr_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between the fetch and load/store channels.
// The pick is combinational; last_grant only moves when a grant is accepted.
module rr_arb2
    import ddr_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic pc_valid,
    input  logic ls_valid,
    input  logic update,
    output logic pc_win,
    output logic ls_win
);

    arb_owner_e last_grant;

    // On a tie the channel that did not win last time goes first.
    always_comb begin
        pc_win = 1'b0;
        ls_win = 1'b0;
        if (pc_valid && ls_valid) begin
            if (last_grant == LS) pc_win = 1'b1;
            else                  ls_win = 1'b1;
        end else begin
            pc_win = pc_valid;
            ls_win = ls_valid;
        end
    end

    // Remember who was granted; LS after reset so fetch wins the first tie.
    always_ff @(posedge clock) begin
        if (reset)       last_grant <= LS;
        else if (update) last_grant <= pc_win ? PC : LS;
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares the single DDR port between instruction fetch (512-bit burst reads)
// and the load/store unit (64-bit masked accesses). One operation at a time:
// handshake -> one-cycle chip enable -> wait for done -> one-cycle response.
module ddr_port_arbiter
    import ddr_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_req_valid,
    output logic              pc_req_ready,
    input  logic [IDX_W-1:0]  pc_req_index,
    input  logic              pc_flush,
    output logic              pc_resp_valid,
    output logic [LINE_W-1:0] pc_resp_inst,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [IDX_W-1:0]  ls_req_index,
    input  logic              ls_req_write,
    input  logic [LS_W-1:0]   ls_req_wmask,
    input  logic [LS_W-1:0]   ls_req_wdata,
    output logic              ls_resp_valid,
    output logic [LS_W-1:0]   ls_resp_rdata,
    output logic              ddr_chip_enable,
    output logic [IDX_W-1:0]  ddr_index,
    output logic              ddr_write_enable,
    output logic              ddr_burst_mode,
    output logic [LS_W-1:0]   ddr_opstore_write_mask,
    output logic [LS_W-1:0]   ddr_opstore_write_data,
    input  logic [LS_W-1:0]   ddr_opload_read_data,
    input  logic [LINE_W-1:0] ddr_pc_read_inst,
    input  logic              ddr_operation_done,
    input  logic              ddr_ready,
    output logic [CNT_W-1:0]  pc_grant_cnt,
    output logic [CNT_W-1:0]  ls_grant_cnt
);

    arb_state_e        state;
    arb_state_e        state_next;
    arb_owner_e        owner;
    ddr_cmd_t          cmd;
    logic              drop;
    logic              pc_win;
    logic              ls_win;
    logic              pc_hs;
    logic              ls_hs;
    logic              op_done;
    logic [LINE_W-1:0] line_q;
    logic [LS_W-1:0]   rdata_q;

    assign pc_hs   = pc_req_valid && pc_req_ready;
    assign ls_hs   = ls_req_valid && ls_req_ready;
    assign op_done = (state == WAIT) && ddr_operation_done;

    assign pc_resp_inst  = line_q;
    assign ls_resp_rdata = rdata_q;

    rr_arb2 u_rr_arb2 (
        .clock    (clock),
        .reset    (reset),
        .pc_valid (pc_req_valid),
        .ls_valid (ls_req_valid),
        .update   (pc_hs || ls_hs),
        .pc_win   (pc_win),
        .ls_win   (ls_win)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state: done is only honoured in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pc_hs || ls_hs) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (ddr_operation_done) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: grants in IDLE, command while the operation is live, response in DRAIN.
    always_comb begin
        pc_req_ready           = 1'b0;
        ls_req_ready           = 1'b0;
        ddr_chip_enable        = 1'b0;
        pc_resp_valid          = 1'b0;
        ls_resp_valid          = 1'b0;
        ddr_index              = '0;
        ddr_write_enable       = 1'b0;
        ddr_burst_mode         = 1'b0;
        ddr_opstore_write_mask = '0;
        ddr_opstore_write_data = '0;
        case (state)
            IDLE: begin
                pc_req_ready = ddr_ready && pc_win;
                ls_req_ready = ddr_ready && ls_win;
            end
            ISSUE, WAIT: begin
                ddr_chip_enable        = (state == ISSUE);
                ddr_index              = cmd.index;
                ddr_write_enable       = cmd.we;
                ddr_burst_mode         = cmd.burst;
                ddr_opstore_write_mask = cmd.mask;
                ddr_opstore_write_data = cmd.data;
            end
            DRAIN: begin
                pc_resp_valid = (owner == PC) && !drop;
                ls_resp_valid = (owner == LS);
            end
            default: ;
        endcase
    end

    // Latch the command on handshake; a fetch is always a burst read with no payload.
    always_ff @(posedge clock) begin
        if (pc_hs) begin
            cmd <= '{index: pc_req_index, we: 1'b0, burst: 1'b1, mask: '0, data: '0};
        end else if (ls_hs) begin
            cmd <= '{index: ls_req_index, we: ls_req_write, burst: 1'b0,
                     mask: ls_req_wmask, data: ls_req_wdata};
        end
    end

    // Owner of the live operation and the flush-drop flag (cleared when leaving DRAIN).
    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= PC;
            drop  <= 1'b0;
        end else begin
            if (pc_hs)      owner <= PC;
            else if (ls_hs) owner <= LS;
            if (state == DRAIN)
                drop <= 1'b0;
            else if (pc_flush && (pc_hs || (owner == PC && (state == ISSUE || state == WAIT))))
                drop <= 1'b1;
        end
    end

    // Capture read data for the owner on done; stores return zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_q  <= '0;
            rdata_q <= '0;
        end else if (op_done) begin
            if (owner == PC) line_q  <= ddr_pc_read_inst;
            else             rdata_q <= cmd.we ? '0 : ddr_opload_read_data;
        end
    end

    // Accepted-request counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_grant_cnt <= '0;
            ls_grant_cnt <= '0;
        end else begin
            if (pc_hs) pc_grant_cnt <= pc_grant_cnt + CNT_W'(1);
            if (ls_hs) ls_grant_cnt <= ls_grant_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: a behavioural DDR model plus per-channel
// scoreboards fed at handshake time and drained when responses appear.
module tb_ddr_port_arbiter;
    import ddr_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              pc_req_valid = 1'b0;
    logic              pc_req_ready;
    logic [IDX_W-1:0]  pc_req_index = '0;
    logic              pc_flush = 1'b0;
    logic              pc_resp_valid;
    logic [LINE_W-1:0] pc_resp_inst;
    logic              ls_req_valid = 1'b0;
    logic              ls_req_ready;
    logic [IDX_W-1:0]  ls_req_index = '0;
    logic              ls_req_write = 1'b0;
    logic [LS_W-1:0]   ls_req_wmask = '0;
    logic [LS_W-1:0]   ls_req_wdata = '0;
    logic              ls_resp_valid;
    logic [LS_W-1:0]   ls_resp_rdata;
    logic              ddr_chip_enable;
    logic [IDX_W-1:0]  ddr_index;
    logic              ddr_write_enable;
    logic              ddr_burst_mode;
    logic [LS_W-1:0]   ddr_opstore_write_mask;
    logic [LS_W-1:0]   ddr_opstore_write_data;
    logic [LS_W-1:0]   ddr_opload_read_data = '0;
    logic [LINE_W-1:0] ddr_pc_read_inst = '0;
    logic              ddr_operation_done = 1'b0;
    logic              ddr_ready = 1'b1;
    logic [CNT_W-1:0]  pc_grant_cnt;
    logic [CNT_W-1:0]  ls_grant_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [LINE_W-1:0] pc_exp_q[$];
    logic [LS_W-1:0]   ls_exp_q[$];
    ddr_cmd_t          cmd_q[$];
    int                grant_q[$];
    logic [LS_W-1:0]   model_mem[int];
    logic [LS_W-1:0]   ref_mem[int];

    bit       busy = 1'b0;
    int       cnt = 0;
    int       done_delay = 3;
    int       done_cyc = -10;
    int       hs_cyc = -10;
    bit       late_done_req = 1'b0;
    int       last_owner = 1;
    int       exp_pc_cnt = 0;
    int       exp_ls_cnt = 0;
    ddr_cmd_t cur_cmd;

    ddr_port_arbiter dut (
        .clock                  (clock),
        .reset                  (reset),
        .pc_req_valid           (pc_req_valid),
        .pc_req_ready           (pc_req_ready),
        .pc_req_index           (pc_req_index),
        .pc_flush               (pc_flush),
        .pc_resp_valid          (pc_resp_valid),
        .pc_resp_inst           (pc_resp_inst),
        .ls_req_valid           (ls_req_valid),
        .ls_req_ready           (ls_req_ready),
        .ls_req_index           (ls_req_index),
        .ls_req_write           (ls_req_write),
        .ls_req_wmask           (ls_req_wmask),
        .ls_req_wdata           (ls_req_wdata),
        .ls_resp_valid          (ls_resp_valid),
        .ls_resp_rdata          (ls_resp_rdata),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready),
        .pc_grant_cnt           (pc_grant_cnt),
        .ls_grant_cnt           (ls_grant_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++)
            l[k*32 +: 32] = ({13'd0, idx} * 32'd40503) ^ (32'h1000_0001 * 32'(k + 1));
        return l;
    endfunction

    // DDR model and response monitor, evaluated once per cycle on the falling edge.
    initial begin
        ddr_cmd_t act_c;
        ddr_cmd_t exp_c;
        logic [LINE_W-1:0] e_line;
        logic [LS_W-1:0]   e_word;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy = 1'b0;
                ddr_operation_done = 1'b0;
            end else begin
                if (ddr_operation_done) begin
                    ddr_operation_done   = 1'b0;
                    busy                 = 1'b0;
                    ddr_opload_read_data = {$urandom, $urandom};
                    ddr_pc_read_inst     = ~line_of(cur_cmd.index);
                end
                act_c = '{index: ddr_index, we: ddr_write_enable, burst: ddr_burst_mode,
                          mask: ddr_opstore_write_mask, data: ddr_opstore_write_data};
                if (ddr_chip_enable) begin
                    n_checks++;
                    if (busy || cmd_q.size() == 0) begin
                        $display("FAIL ce_unexpected: chip_enable at cycle %0d with busy=%0d queued=%0d, required none",
                                 cyc, busy, cmd_q.size());
                    end else begin
                        exp_c = cmd_q.pop_front();
                        if (act_c !== exp_c || cyc != hs_cyc + 1)
                            $display("FAIL cmd_issue: got %h at cycle %0d, required %h at cycle %0d",
                                     act_c, cyc, exp_c, hs_cyc + 1);
                        else
                            n_pass++;
                        cur_cmd = exp_c;
                        busy    = 1'b1;
                        cnt     = done_delay;
                        if (exp_c.we) begin
                            e_word = model_mem.exists(int'(exp_c.index)) ? model_mem[int'(exp_c.index)] : '0;
                            model_mem[int'(exp_c.index)] = (e_word & ~exp_c.mask) | (exp_c.data & exp_c.mask);
                        end
                    end
                end else if (busy) begin
                    n_checks++;
                    if (act_c !== cur_cmd)
                        $display("FAIL cmd_stable: got %h, required %h", act_c, cur_cmd);
                    else
                        n_pass++;
                end else begin
                    n_checks++;
                    if (act_c !== '0)
                        $display("FAIL cmd_idle: got %h, required 0", act_c);
                    else
                        n_pass++;
                end
                if (pc_resp_valid) begin
                    n_checks++;
                    if (pc_exp_q.size() == 0) begin
                        $display("FAIL pc_resp_unexpected: pc_resp_valid=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e_line = pc_exp_q.pop_front();
                        if (pc_resp_inst !== e_line || cyc != done_cyc + 1)
                            $display("FAIL pc_resp: got %h at cycle %0d, required %h at cycle %0d",
                                     pc_resp_inst, cyc, e_line, done_cyc + 1);
                        else
                            n_pass++;
                    end
                end
                if (ls_resp_valid) begin
                    n_checks++;
                    if (ls_exp_q.size() == 0) begin
                        $display("FAIL ls_resp_unexpected: ls_resp_valid=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e_word = ls_exp_q.pop_front();
                        if (ls_resp_rdata !== e_word || cyc != done_cyc + 1)
                            $display("FAIL ls_resp: got %h at cycle %0d, required %h at cycle %0d",
                                     ls_resp_rdata, cyc, e_word, done_cyc + 1);
                        else
                            n_pass++;
                    end
                end
                if (late_done_req) begin
                    late_done_req      = 1'b0;
                    ddr_operation_done = 1'b1;
                end else if (busy && !ddr_chip_enable) begin
                    cnt--;
                end
                if (busy && cnt <= 0 && !ddr_operation_done) begin
                    ddr_operation_done = 1'b1;
                    done_cyc           = cyc;
                    ddr_pc_read_inst   = cur_cmd.burst ? line_of(cur_cmd.index) : ~line_of(cur_cmd.index);
                    if (!cur_cmd.burst && !cur_cmd.we)
                        ddr_opload_read_data = model_mem.exists(int'(cur_cmd.index)) ? model_mem[int'(cur_cmd.index)] : '0;
                    else
                        ddr_opload_read_data = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic pc_request(input logic [IDX_W-1:0] idx, input bit expect_resp, input bit flush_hs);
        bit got;
        got = 1'b0;
        @(negedge clock);
        pc_req_valid = 1'b1;
        pc_req_index = idx;
        if (flush_hs) pc_flush = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (pc_req_ready) begin
                got = 1'b1;
                if (expect_resp) pc_exp_q.push_back(line_of(idx));
                cmd_q.push_back('{index: idx, we: 1'b0, burst: 1'b1, mask: '0, data: '0});
                grant_q.push_back(0);
                last_owner = 0;
                exp_pc_cnt++;
                hs_cyc = cyc;
            end
            @(negedge clock);
        end
        pc_req_valid = 1'b0;
        if (flush_hs) pc_flush = 1'b0;
        n_checks++;
        if (!got) $display("FAIL pc_handshake: no ready within 200 cycles for index %h", idx);
        else      n_pass++;
    endtask

    task automatic ls_request(input logic [IDX_W-1:0] idx, input bit wr,
                              input logic [LS_W-1:0] mask, input logic [LS_W-1:0] data);
        bit got;
        logic [LS_W-1:0] old;
        got = 1'b0;
        @(negedge clock);
        ls_req_valid = 1'b1;
        ls_req_index = idx;
        ls_req_write = wr;
        ls_req_wmask = mask;
        ls_req_wdata = data;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (ls_req_ready) begin
                got = 1'b1;
                old = ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : '0;
                if (wr) begin
                    ref_mem[int'(idx)] = (old & ~mask) | (data & mask);
                    ls_exp_q.push_back('0);
                end else begin
                    ls_exp_q.push_back(old);
                end
                cmd_q.push_back('{index: idx, we: wr, burst: 1'b0, mask: mask, data: data});
                grant_q.push_back(1);
                last_owner = 1;
                exp_ls_cnt++;
                hs_cyc = cyc;
            end
            @(negedge clock);
        end
        ls_req_valid = 1'b0;
        n_checks++;
        if (!got) $display("FAIL ls_handshake: no ready within 200 cycles for index %h", idx);
        else      n_pass++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        #2;
        while ((pc_exp_q.size() != 0 || ls_exp_q.size() != 0 || cmd_q.size() != 0 ||
                busy || ddr_operation_done) && n < 200) begin
            @(negedge clock);
            #2;
            n++;
        end
        n_checks++;
        if (n >= 200)
            $display("FAIL wait_idle: still pending pc=%0d ls=%0d cmd=%0d after 200 cycles, required 0",
                     pc_exp_q.size(), ls_exp_q.size(), cmd_q.size());
        else
            n_pass++;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ddr_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if ({pc_req_ready, ls_req_ready, ddr_chip_enable, pc_resp_valid, ls_resp_valid} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {pc_req_ready, ls_req_ready, ddr_chip_enable, pc_resp_valid, ls_resp_valid});
        else n_pass++;
        n_checks++;
        if ({ddr_index, ddr_write_enable, ddr_burst_mode, ddr_opstore_write_mask, ddr_opstore_write_data} !== '0)
            $display("FAIL reset_cmd: got index %h we %b burst %b, required 0", ddr_index, ddr_write_enable, ddr_burst_mode);
        else n_pass++;
        n_checks++;
        if (pc_resp_inst !== '0 || ls_resp_rdata !== '0)
            $display("FAIL reset_data: got rdata %h, required 0", ls_resp_rdata);
        else n_pass++;
        n_checks++;
        if (pc_grant_cnt !== '0 || ls_grant_cnt !== '0)
            $display("FAIL reset_cnt: got %0d/%0d, required 0/0", pc_grant_cnt, ls_grant_cnt);
        else n_pass++;
        reset = 1'b0;
        last_owner = 1;
        exp_pc_cnt = 0;
        exp_ls_cnt = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_round_robin();
        grant_q.delete();
        done_delay = 2;
        fork
            begin
                for (int i = 0; i < 3; i++) pc_request(19'h00200 + 19'(i), 1'b1, 1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) ls_request(19'h00300 + 19'(i), 1'b0, '0, '0);
            end
        join
        wait_idle();
        n_checks++;
        if (grant_q.size() != 6) $display("FAIL rr_count: got %0d grants, required 6", grant_q.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            n_checks++;
            if (grant_q[i] != i % 2)
                $display("FAIL rr_order: grant %0d went to %0d, required %0d", i, grant_q[i], i % 2);
            else n_pass++;
        end
        n_checks++;
        if (pc_grant_cnt !== 32'd3 || ls_grant_cnt !== 32'd3)
            $display("FAIL rr_cnt: got %0d/%0d, required 3/3", pc_grant_cnt, ls_grant_cnt);
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        done_delay = 5;
        pc_request(19'h00040, 1'b1, 1'b0);
        wait_idle();
        n_checks++;
        if (pc_grant_cnt !== 32'(exp_pc_cnt))
            $display("FAIL fetch_cnt: got %0d, required %0d", pc_grant_cnt, exp_pc_cnt);
        else n_pass++;
    endtask

    task automatic test_store_load();
        done_delay = 3;
        ls_request(19'h00100, 1'b1, 64'h0000_0000_0000_00FF, 64'hDEAD_BEEF_CAFE_F00D);
        wait_idle();
        ls_request(19'h00100, 1'b0, '0, '0);
        wait_idle();
        n_checks++;
        if (ls_resp_rdata[7:0] !== 8'h0D)
            $display("FAIL load_low_byte: got %h, required 0d", ls_resp_rdata[7:0]);
        else n_pass++;
        done_delay = 2;
        ls_request(19'h00100, 1'b1, 64'hFFFF_0000_0000_0000, 64'h1234_5678_9ABC_DEF0);
        wait_idle();
        ls_request(19'h00100, 1'b0, '0, '0);
        wait_idle();
        n_checks++;
        if (ls_grant_cnt !== 32'(exp_ls_cnt))
            $display("FAIL ls_cnt: got %0d, required %0d", ls_grant_cnt, exp_ls_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        done_delay = 6;
        pc_request(19'h00080, 1'b0, 1'b0);
        @(negedge clock);
        pc_flush  = 1'b1;
        ddr_ready = 1'b0;
        @(negedge clock);
        pc_flush = 1'b0;
        @(negedge clock);
        ddr_ready = 1'b1;
        wait_idle();
        done_delay = 3;
        pc_request(19'h00081, 1'b1, 1'b0);
        wait_idle();
        pc_request(19'h00082, 1'b0, 1'b1);
        wait_idle();
        pc_flush = 1'b1;
        ls_request(19'h00100, 1'b0, '0, '0);
        wait_idle();
        @(negedge clock);
        pc_flush = 1'b0;
        pc_request(19'h00083, 1'b1, 1'b0);
        wait_idle();
    endtask

    task automatic test_not_ready();
        bit exp_pc;
        @(negedge clock);
        ddr_ready    = 1'b0;
        pc_req_valid = 1'b1;
        pc_req_index = 19'h00400;
        ls_req_valid = 1'b1;
        ls_req_index = 19'h00401;
        ls_req_write = 1'b0;
        ls_req_wmask = '0;
        ls_req_wdata = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (pc_req_ready !== 1'b0 || ls_req_ready !== 1'b0)
                $display("FAIL not_ready: cycle %0d got ready %b%b, required 00", i, pc_req_ready, ls_req_ready);
            else n_pass++;
            @(negedge clock);
        end
        exp_pc = (last_owner == 1);
        ddr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_req_ready !== exp_pc || ls_req_ready !== !exp_pc)
            $display("FAIL ready_rise: got %b%b, required %b%b", pc_req_ready, ls_req_ready, exp_pc, !exp_pc);
        else n_pass++;
        #1;
        pc_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        done_delay = 2;
        fork
            pc_request(19'h00400, 1'b1, 1'b0);
            ls_request(19'h00401, 1'b0, '0, '0);
        join
        wait_idle();
    endtask

    task automatic test_reset_mid_op();
        done_delay = 8;
        pc_request(19'h00090, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        n_checks++;
        if ({pc_req_ready, ls_req_ready, ddr_chip_enable, pc_resp_valid, ls_resp_valid} !== 5'b0 ||
            {ddr_index, ddr_write_enable, ddr_burst_mode, ddr_opstore_write_mask, ddr_opstore_write_data} !== '0)
            $display("FAIL midreset_ctrl: got ce %b index %h burst %b, required 0", ddr_chip_enable, ddr_index, ddr_burst_mode);
        else n_pass++;
        n_checks++;
        if (pc_resp_inst !== '0 || ls_resp_rdata !== '0 || pc_grant_cnt !== '0 || ls_grant_cnt !== '0)
            $display("FAIL midreset_data: got rdata %h cnt %0d/%0d, required 0", ls_resp_rdata, pc_grant_cnt, ls_grant_cnt);
        else n_pass++;
        reset = 1'b0;
        last_owner = 1;
        exp_pc_cnt = 0;
        exp_ls_cnt = 0;
        late_done_req = 1'b1;
        repeat (4) @(negedge clock);
        done_delay = 3;
        pc_request(19'h00091, 1'b1, 1'b0);
        wait_idle();
        n_checks++;
        if (pc_grant_cnt !== 32'd1 || ls_grant_cnt !== 32'd0)
            $display("FAIL midreset_cnt: got %0d/%0d, required 1/0", pc_grant_cnt, ls_grant_cnt);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_fetch();
        test_store_load();
        test_flush();
        test_not_ready();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
